stim_pattern_gen: RTL and testbench
===================================

# stim_pattern_gen

Clocked, parametrised stimulus generator that replaces hand-written toggling-input testbench stimulus for small combinational blocks. It steps a WIDTH-bit pattern through a selectable sequence (binary up, Gray, walking-one, binary down), holds each pattern for HOLD_CYCLES clocks, and compacts the DUT response into a rotate-XOR signature. It sits between the bench control logic and the DUT inputs/outputs. It is synthesisable, so it can also drive on-board self-test.

## Interface
- WIDTH, 4, pattern width in bits; 2..16.
- HOLD_CYCLES, 50, clocks each pattern is held; ≥1.
- RESP_W, 4, width of DUT response and signature; ≥2.
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  start a sequence; sampled only in IDLE.
- stop  in  1  abort the running sequence; sampled only in RUN.
- mode  in  2  sequence select, latched on accepted start: 00 binary up, 01 Gray, 10 walking-one, 11 binary down.
- loop  in  1  repeat the sequence continuously; latched on accepted start.
- resp  in  RESP_W  DUT response, sampled on the last hold cycle of each pattern.
- pattern  out  WIDTH  stimulus to the DUT, registered.
- valid  out  1  pattern is being driven.
- busy  out  1  sequence in progress.
- idx  out  WIDTH+1  current pattern index.
- done  out  1  one-cycle pulse at the end of each pass.
- sig  out  RESP_W  response signature.

## Operation
- States: IDLE and RUN.
- Reset (rst_n=0 at an edge, in either state): state IDLE; pattern, valid, busy, idx, done and sig all 0.
- IDLE→RUN on start=1: latch mode and loop; idx=0; pattern=f(0); sig=0; hold counter=HOLD_CYCLES-1; valid=busy=1.
- Pattern function f(i):
  - binary up: i[WIDTH-1:0].
  - Gray: i^(i>>1).
  - walking-one: 1<<i.
  - binary down: ~i[WIDTH-1:0], i.e. all-ones minus i.
- Pass length N: 2^WIDTH for modes 00, 01 and 11; WIDTH for mode 10.
- Hold counter in RUN: decrements each cycle. When it is 0 (the last hold cycle):
  - sig <= rotl(sig,1) ^ resp.
  - idx advances and the counter reloads to HOLD_CYCLES-1.
- End of pass (last hold cycle of idx=N-1):
  - loop=0: next cycle state=IDLE, valid=busy=0, pattern=0, idx=0, done=1 for one cycle. sig holds until the next start.
  - loop=1: next cycle idx=0, pattern=f(0), done=1 for one cycle, valid and busy stay 1. sig is not cleared.
- stop=1 in RUN: next cycle state=IDLE, valid=busy=0, pattern=0, idx=0, no done pulse, sig holds.
- Priority in RUN: stop wins over end-of-pass, so no done is issued. Reset wins over everything.
- start in RUN is ignored. stop in IDLE is ignored. start=stop=1 in IDLE: start is accepted.
- mode and loop changes during RUN have no effect.

## Timing
- start accepted at edge k: pattern f(0) is visible from cycle k+1.
- Pattern i is visible for cycles k+1+i·H through k+i·H+H, where H=HOLD_CYCLES.
- resp is sampled at the edge ending cycle k+(i+1)·H. The updated sig is visible the cycle after.
- done is high in cycle k+1+N·H. With loop=0, busy falls in that same cycle.
- All outputs are registered; there is no combinational path from the inputs to the outputs.
- HOLD_CYCLES=1: the pattern changes every cycle and resp is sampled every cycle.

## Test plan
- Reset: WIDTH=4, H=2, run binary; drive rst_n=0 at cycle 10 → at the next edge pattern=0, valid=busy=done=0, idx=0, sig=0; start after rst_n=1 restarts from pattern 0.
- Binary up, H=2, start at edge 0 → pattern 0,0,1,1,…,F,F over cycles 1–32; done=1 and busy=0 in cycle 33.
- Gray, H=2 → patterns 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8; each consecutive pair differs in exactly one bit; done in cycle 33.
- Walking-one, H=1 → pattern 1,2,4,8 in cycles 1–4; done in cycle 5; binary down, H=1 → F,E,…,0.
- Loop + stop: binary, loop=1, H=2 → cycle 33 shows pattern 0 with done=1 and valid=1; stop at cycle 40 → cycle 41 valid=busy=0 with no done; a start in cycle 20 is ignored.
- Signature: binary, RESP_W=4, resp=pattern (loopback), H=2 → sig=0xF after pattern 7 is sampled; final sig=0x0; sig holds after done until the next start clears it.

Source files
------------

// File: rtl/stim_pattern_gen.sv
// rtl/stim_pattern_gen.sv - sequenced stimulus pattern generator with rotate-XOR response signature
// Steps a WIDTH-bit pattern through binary/Gray/walking-one/down sequences, holding each for HOLD_CYCLES clocks.

module stim_pattern_gen #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 50,
  parameter int RESP_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic              loop,
  input  logic [RESP_W-1:0] resp,
  output logic [WIDTH-1:0]  pattern,
  output logic              valid,
  output logic              busy,
  output logic [WIDTH:0]    idx,
  output logic              done,
  output logic [RESP_W-1:0] sig
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_GRAY = 2'b01;
  localparam logic [1:0] MODE_WALK = 2'b10;

  localparam logic [WIDTH:0] LAST_FULL = (WIDTH+1)'((1 << WIDTH) - 1);
  localparam logic [WIDTH:0] LAST_WALK = (WIDTH+1)'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [1:0]        mode_q, mode_n;
  logic              loop_q, loop_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [WIDTH-1:0]  pattern_n;
  logic              valid_n;
  logic              busy_n;
  logic [WIDTH:0]    idx_n;
  logic              done_n;
  logic [RESP_W-1:0] sig_n;
  logic [WIDTH:0]    last_idx;
  logic [WIDTH:0]    idx_inc;

  function automatic logic [WIDTH-1:0] pat_of(input logic [1:0] m, input logic [WIDTH:0] i);
    logic [WIDTH-1:0] b;
    b = i[WIDTH-1:0];
    case (m)
      MODE_BIN:  return b;
      MODE_GRAY: return b ^ (b >> 1);
      MODE_WALK: return WIDTH'(1) << b;
      default:   return ~b;
    endcase
  endfunction

  function automatic logic [RESP_W-1:0] rotl1(input logic [RESP_W-1:0] s);
    return {s[RESP_W-2:0], s[RESP_W-1]};
  endfunction

  assign last_idx = (mode_q == MODE_WALK) ? LAST_WALK : LAST_FULL;
  assign idx_inc  = idx + 1'b1;

  always_comb begin
    state_n   = state;
    mode_n    = mode_q;
    loop_n    = loop_q;
    cnt_n     = cnt;
    pattern_n = pattern;
    valid_n   = valid;
    busy_n    = busy;
    idx_n     = idx;
    done_n    = 1'b0;
    sig_n     = sig;

    case (state)
      S_IDLE: begin
        // start beats a simultaneous stop here; stop only matters while running
        if (start) begin
          state_n   = S_RUN;
          mode_n    = mode;
          loop_n    = loop;
          idx_n     = '0;
          pattern_n = pat_of(mode, '0);
          sig_n     = '0;
          cnt_n     = RELOAD;
          valid_n   = 1'b1;
          busy_n    = 1'b1;
        end
      end

      S_RUN: begin
        if (stop) begin
          state_n   = S_IDLE;
          valid_n   = 1'b0;
          busy_n    = 1'b0;
          pattern_n = '0;
          idx_n     = '0;
        end else if (cnt == '0) begin
          sig_n = rotl1(sig) ^ resp;
          cnt_n = RELOAD;
          if (idx == last_idx) begin
            done_n = 1'b1;
            idx_n  = '0;
            if (loop_q) begin
              pattern_n = pat_of(mode_q, '0);
            end else begin
              state_n   = S_IDLE;
              valid_n   = 1'b0;
              busy_n    = 1'b0;
              pattern_n = '0;
            end
          end else begin
            idx_n     = idx_inc;
            pattern_n = pat_of(mode_q, idx_inc);
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mode_q  <= MODE_BIN;
      loop_q  <= 1'b0;
      cnt     <= '0;
      pattern <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      idx     <= '0;
      done    <= 1'b0;
      sig     <= '0;
    end else begin
      state   <= state_n;
      mode_q  <= mode_n;
      loop_q  <= loop_n;
      cnt     <= cnt_n;
      pattern <= pattern_n;
      valid   <= valid_n;
      busy    <= busy_n;
      idx     <= idx_n;
      done    <= done_n;
      sig     <= sig_n;
    end
  end

endmodule

// File: tb/tb_stim_pattern_gen.sv
// tb/tb_stim_pattern_gen.sv - directed bench for stim_pattern_gen
// Unit a: WIDTH=4, H=2, response looped back from pattern; unit b: WIDTH=4, H=1.

module tb_stim_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, stop_a, loop_a;
  logic [1:0] mode_a;
  logic [3:0] pattern_a, sig_a;
  logic       valid_a, busy_a, done_a;
  logic [4:0] idx_a;

  logic       start_b, stop_b, loop_b;
  logic [1:0] mode_b;
  logic [3:0] resp_b;
  logic [3:0] pattern_b, sig_b;
  logic       valid_b, busy_b, done_b;
  logic [4:0] idx_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [3:0] walk_tab [4]  = '{4'h1, 4'h2, 4'h4, 4'h8};
  logic [3:0] prev;

  stim_pattern_gen #(.WIDTH(4), .HOLD_CYCLES(2), .RESP_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .mode(mode_a),
    .loop(loop_a), .resp(pattern_a), .pattern(pattern_a), .valid(valid_a),
    .busy(busy_a), .idx(idx_a), .done(done_a), .sig(sig_a)
  );

  stim_pattern_gen #(.WIDTH(4), .HOLD_CYCLES(1), .RESP_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .mode(mode_b),
    .loop(loop_b), .resp(resp_b), .pattern(pattern_b), .valid(valid_b),
    .busy(busy_b), .idx(idx_b), .done(done_b), .sig(sig_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 0; stop_a = 0; loop_a = 0; mode_a = 2'b00;
    start_b = 0; stop_b = 0; loop_b = 0; mode_b = 2'b00; resp_b = 4'h0;
    tick(); tick();
    check("rst_pattern", pattern_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_idx", idx_a, 0);
    check("rst_done", done_a, 0);
    check("rst_sig", sig_a, 0);
    check("rst_b_busy", busy_b, 0);
    rst_n = 1'b1;
    tick();

    // binary up, H=2; mode/loop wiggled after start must not matter
    mode_a = 2'b00; loop_a = 0; start_a = 1;
    tick();
    start_a = 0; mode_a = 2'b10; loop_a = 1;
    for (int c = 1; c <= 32; c++) begin
      check("bin_pattern", pattern_a, (c - 1) / 2);
      check("bin_valid", valid_a, 1);
      if (c == 17) check("sig_after_7", sig_a, 4'hF);
      tick();
    end
    check("bin_done", done_a, 1);
    check("bin_busy_end", busy_a, 0);
    check("bin_valid_end", valid_a, 0);
    check("bin_pattern_end", pattern_a, 0);
    check("bin_idx_end", idx_a, 0);
    check("sig_final", sig_a, 4'h0);
    tick();
    check("bin_done_pulse", done_a, 0);
    check("sig_hold", sig_a, 4'h0);

    // Gray, H=2
    mode_a = 2'b01; loop_a = 0; start_a = 1;
    tick();
    start_a = 0;
    prev = 4'h0;
    for (int c = 1; c <= 32; c++) begin
      check("gray_pattern", pattern_a, gray_tab[(c - 1) / 2]);
      if (c > 1 && (c % 2) == 1) check("gray_onebit", $countones(pattern_a ^ prev), 1);
      prev = pattern_a;
      tick();
    end
    check("gray_done", done_a, 1);
    check("gray_busy_end", busy_a, 0);

    // loop + ignored start + stop
    mode_a = 2'b00; loop_a = 1; start_a = 1;
    tick();
    start_a = 0;
    for (int c = 1; c <= 40; c++) begin
      start_a = (c == 20);
      stop_a  = (c == 40);
      if (c == 21) begin
        check("loop_pat21", pattern_a, 4'hA);
        check("loop_idx21", idx_a, 10);
      end
      if (c == 33) begin
        check("loop_pat33", pattern_a, 0);
        check("loop_done33", done_a, 1);
        check("loop_valid33", valid_a, 1);
        check("loop_busy33", busy_a, 1);
      end
      tick();
    end
    start_a = 0; stop_a = 0;
    check("stop_valid", valid_a, 0);
    check("stop_busy", busy_a, 0);
    check("stop_done", done_a, 0);
    check("stop_pattern", pattern_a, 0);
    check("stop_idx", idx_a, 0);

    // reset mid-run, then restart from pattern 0
    mode_a = 2'b00; loop_a = 0; start_a = 1;
    tick();
    start_a = 0;
    for (int c = 1; c <= 9; c++) tick();
    check("pre_rst_pattern", pattern_a, 4);
    rst_n = 0;
    tick();
    rst_n = 1;
    check("mid_rst_pattern", pattern_a, 0);
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_idx", idx_a, 0);
    check("mid_rst_sig", sig_a, 0);
    start_a = 1;
    tick();
    start_a = 0;
    check("restart_p0a", pattern_a, 0);
    check("restart_valid", valid_a, 1);
    tick();
    check("restart_p0b", pattern_a, 0);
    tick();
    check("restart_p1", pattern_a, 1);
    stop_a = 1;
    tick();
    stop_a = 0;

    // walking-one, H=1
    mode_b = 2'b10; start_b = 1;
    tick();
    start_b = 0;
    for (int c = 1; c <= 4; c++) begin
      check("walk_pattern", pattern_b, walk_tab[c - 1]);
      check("walk_idx", idx_b, c - 1);
      tick();
    end
    check("walk_done", done_b, 1);
    check("walk_busy_end", busy_b, 0);
    check("walk_pattern_end", pattern_b, 0);

    // binary down, H=1, start and stop together in IDLE
    mode_b = 2'b11; start_b = 1; stop_b = 1;
    tick();
    start_b = 0; stop_b = 0;
    for (int c = 1; c <= 16; c++) begin
      check("down_pattern", pattern_b, 15 - (c - 1));
      check("down_busy", busy_b, 1);
      tick();
    end
    check("down_done", done_b, 1);
    check("down_busy_end", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
